// File: rtl/oq_dst_dispatch_pkg.sv
// Shared constants and FSM encoding for the output-queue destination dispatcher.
package oq_dst_dispatch_pkg;

    typedef enum logic [1:0] {
        StWaitHdr = 2'd0,
        StFwd     = 2'd1,
        StDrop    = 2'd2
    } state_e;

    localparam int unsigned FIFO_DEPTH_BITS        = 2;
    localparam int unsigned IO_QUEUE_STAGE_NUM_DEF = 32'h0000_00ff;
    localparam int unsigned IOQ_DST_PORT_POS       = 48;

endpackage

// File: rtl/oq_dst_dispatch_fifo.sv
// Small first-word-fall-through FIFO; the head word is visible on dout while non-empty.
module oq_dst_dispatch_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_FULL = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_NF   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr       = wr_en && (depth != DEPTH_FULL);
    assign do_rd       = rd_en && (depth != '0);
    assign dout        = mem[rd_ptr];
    assign nearly_full = (depth >= DEPTH_NF);
    assign empty       = (depth == '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd) begin
                depth <= depth + 1'b1;
            end else if (!do_wr && do_rd) begin
                depth <= depth - 1'b1;
            end
        end
    end

endmodule

// File: rtl/oq_dst_dispatch.sv
// Steers each packet to the output ports named in its IOQ header, dropping packets
// with a missing header or an empty destination mask.
module oq_dst_dispatch
    import oq_dst_dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int unsigned NUM_OUTPUT_QUEUES  = 8,
    parameter int unsigned IO_QUEUE_STAGE_NUM = IO_QUEUE_STAGE_NUM_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
    output logic [31:0]                  drop_count
);

    localparam int unsigned WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [CTRL_WIDTH-1:0] HDR_CTRL = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);

    logic [WORD_WIDTH-1:0]        fifo_dout;
    logic                         fifo_empty;
    logic                         fifo_nearly_full;
    logic [DATA_WIDTH-1:0]        head_data;
    logic [CTRL_WIDTH-1:0]        head_ctrl;
    logic [NUM_OUTPUT_QUEUES-1:0] head_mask;
    logic                         head_good;
    logic                         ports_rdy;
    logic                         pop;
    logic                         eop;
    logic                         latch_mask;
    logic                         count_drop;
    state_e                       state;
    state_e                       state_next;
    logic                         in_pkt;
    logic [NUM_OUTPUT_QUEUES-1:0] dst_mask;

    oq_dst_dispatch_fifo #(
        .WIDTH          (WORD_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (pop),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign in_rdy               = !fifo_nearly_full;
    assign {head_ctrl, head_data} = fifo_dout;
    assign head_mask            = head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
    assign head_good            = (head_ctrl == HDR_CTRL) && (head_mask != '0);
    // Multicast waits until every selected port can take the word.
    assign ports_rdy            = &(out_rdy | ~dst_mask);
    assign eop                  = pop && in_pkt && (head_ctrl != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StWaitHdr;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            StWaitHdr: if (!fifo_empty) state_next = head_good ? StFwd : StDrop;
            StFwd:     if (eop) state_next = StWaitHdr;
            StDrop:    if (eop) state_next = StWaitHdr;
            default:   state_next = StWaitHdr;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        latch_mask = 1'b0;
        count_drop = 1'b0;
        case (state)
            StWaitHdr: begin
                latch_mask = !fifo_empty && head_good;
                count_drop = !fifo_empty && !head_good;
            end
            StFwd:   pop = !fifo_empty && ports_rdy;
            StDrop:  pop = !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_pkt     <= 1'b0;
            dst_mask   <= '0;
            out_wr     <= '0;
            out_data   <= '0;
            out_ctrl   <= '0;
            drop_count <= '0;
        end else begin
            if (latch_mask) dst_mask <= head_mask;
            if (pop) begin
                if (head_ctrl == '0) begin
                    in_pkt <= 1'b1;
                end else if (in_pkt) begin
                    in_pkt <= 1'b0;
                end
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
            out_wr <= (state == StFwd && pop) ? dst_mask : '0;
            if (count_drop && drop_count != 32'hFFFF_FFFF) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_oq_dst_dispatch.sv
// Bench: directed and randomized packets checked against a packet-level model of
// the expected (mask, word) sequence on the shared output bus and the drop count.
module tb_oq_dst_dispatch;
    import oq_dst_dispatch_pkg::*;

    localparam logic [7:0] HDR_CTRL = 8'(IO_QUEUE_STAGE_NUM_DEF);
    localparam int unsigned MASK_POS = IOQ_DST_PORT_POS;
    localparam int GUARD = 2000;

    typedef struct packed {
        logic [7:0]  mask;
        logic [71:0] word;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [7:0]  out_wr;
    logic [7:0]  out_rdy;
    logic [31:0] drop_count;

    int   tests = 0;
    int   fails = 0;
    exp_t expq[$];
    int   exp_drops = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   first_wr = -1;
    int   last_wr = -1;
    bit   rand_done;

    oq_dst_dispatch dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: every strobe must match the next expected (mask, word).
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            cyc++;
            if (out_wr !== 8'h00) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (expq.size() == 0) begin
                    check("unexpected_wr", 72'(out_wr), 72'(0));
                end else begin
                    e = expq.pop_front();
                    check("out_wr_mask", 72'(out_wr), 72'(e.mask));
                    check("out_word", {out_ctrl, out_data}, e.word);
                end
            end
        end
    end

    task automatic put_word(input logic [71:0] w);
        int guard = 0;
        @(negedge clk);
        in_wr = 1'b0;
        while (in_rdy !== 1'b1 && guard < GUARD) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= GUARD) check("in_rdy_timeout", 72'(in_rdy), 72'(1));
        in_wr = 1'b1;
        {in_ctrl, in_data} = w;
    endtask

    // Builds a packet, records what the dispatcher should do with it, then drives it.
    task automatic send_pkt(input logic [7:0] hctrl, input logic [7:0] mask, input int npay,
                            input bit extra, input bit partial);
        logic [71:0] words[$];
        logic [63:0] d;
        logic [7:0]  c;
        d = {$urandom, $urandom};
        d[MASK_POS +: 8] = mask;
        words.push_back({hctrl, d});
        if (extra && !partial) words.push_back({8'h40, $urandom, $urandom});
        for (int i = 0; i < npay; i++) words.push_back({8'h00, $urandom, $urandom});
        if (!partial) begin
            c = 8'($urandom_range(1, 255));
            words.push_back({c, $urandom, $urandom});
            if (hctrl == HDR_CTRL && mask != 8'h00) begin
                foreach (words[i]) expq.push_back('{mask: mask, word: words[i]});
            end else begin
                exp_drops++;
            end
        end
        foreach (words[i]) put_word(words[i]);
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expq.size() != 0 && n < GUARD) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check({tag, "_drained"}, 72'(expq.size()), 72'(0));
        check({tag, "_drop_count"}, 72'(drop_count), 72'(exp_drops));
        check({tag, "_in_rdy_idle"}, 72'(in_rdy), 72'(1));
    endtask

    initial begin
        reset   = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        in_wr   = 1'b0;
        out_rdy = 8'hff;
        repeat (3) @(negedge clk);
        check("rst_in_rdy", 72'(in_rdy), 72'(1));
        check("rst_out_wr", 72'(out_wr), 72'(0));
        check("rst_drop_count", 72'(drop_count), 72'(0));
        reset = 1'b0;

        // Single-port packet streams out in exactly four back-to-back cycles.
        wr_cnt = 0;
        first_wr = -1;
        send_pkt(HDR_CTRL, 8'h04, 2, 1'b0, 1'b0);
        drain("unicast");
        check("unicast_wr_cycles", 72'(wr_cnt), 72'(4));
        check("unicast_contiguous", 72'(last_wr - first_wr), 72'(3));

        // Multicast stalls while one selected port is busy.
        out_rdy = 8'h01;
        fork
            send_pkt(HDR_CTRL, 8'h05, 2, 1'b0, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_no_wr", 72'(out_wr), 72'(0));
                end
                out_rdy = 8'hff;
            end
        join
        drain("multicast");

        // Empty mask, then a normal packet.
        send_pkt(HDR_CTRL, 8'h00, 2, 1'b0, 1'b0);
        send_pkt(HDR_CTRL, 8'h02, 3, 1'b1, 1'b0);
        drain("zero_mask");
        check("zero_mask_drops", 72'(drop_count), 72'(1));

        // Missing IOQ header.
        send_pkt(8'h33, 8'h08, 2, 1'b1, 1'b0);
        send_pkt(HDR_CTRL, 8'h08, 1, 1'b0, 1'b0);
        drain("bad_hdr");
        check("bad_hdr_drops", 72'(drop_count), 72'(2));

        // Reset in the middle of a packet discards it.
        out_rdy = 8'h00;
        send_pkt(HDR_CTRL, 8'h10, 2, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_wr", 72'(out_wr), 72'(0));
        check("midrst_in_rdy", 72'(in_rdy), 72'(1));
        check("midrst_drop_count", 72'(drop_count), 72'(0));
        exp_drops = 0;
        @(negedge clk);
        check("midrst_out_wr_hold", 72'(out_wr), 72'(0));
        reset   = 1'b0;
        out_rdy = 8'hff;
        @(negedge clk);
        check("postrst_in_rdy", 72'(in_rdy), 72'(1));
        send_pkt(HDR_CTRL, 8'h80, 2, 1'b0, 1'b0);
        drain("post_reset");

        // Back-pressure: nothing ready, FIFO fills to nearly-full.
        out_rdy = 8'h00;
        fork
            begin
                send_pkt(HDR_CTRL, 8'h21, 3, 1'b0, 1'b0);
                send_pkt(HDR_CTRL, 8'h42, 2, 1'b1, 1'b0);
            end
            begin
                int n = 0;
                while (in_rdy !== 1'b0 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("nearly_full_in_rdy", 72'(in_rdy), 72'(0));
                repeat (4) @(negedge clk);
                check("backpressure_in_rdy", 72'(in_rdy), 72'(0));
                check("backpressure_no_wr", 72'(out_wr), 72'(0));
                out_rdy = 8'hff;
            end
        join
        drain("backpressure");

        // Randomized traffic with random port readiness.
        rand_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    logic [7:0] hc;
                    logic [7:0] m;
                    hc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 254)) : HDR_CTRL;
                    m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    send_pkt(hc, m, $urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'b0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_rdy = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hff;
                end
                out_rdy = 8'hff;
            end
        join
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
